// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// ALU control codes: ctrl[4] selects compare/branch, ctrl[3] the alternate op, ctrl[2:0] funct3.
package alu_arbiter_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    typedef logic [0:0] req_idx_t;

    localparam int CNT_W  = 16;
    localparam int CTRL_W = 6;

    localparam logic [CTRL_W-1:0] ALU_ADD   = 6'b000000;
    localparam logic [CTRL_W-1:0] ALU_SUB   = 6'b001000;
    localparam logic [CTRL_W-1:0] ALU_SLL   = 6'b000001;
    localparam logic [CTRL_W-1:0] ALU_SLT   = 6'b000010;
    localparam logic [CTRL_W-1:0] ALU_SLTU  = 6'b000011;
    localparam logic [CTRL_W-1:0] ALU_XOR   = 6'b000100;
    localparam logic [CTRL_W-1:0] ALU_SRL   = 6'b000101;
    localparam logic [CTRL_W-1:0] ALU_SRA   = 6'b001101;
    localparam logic [CTRL_W-1:0] ALU_OR    = 6'b000110;
    localparam logic [CTRL_W-1:0] ALU_AND   = 6'b000111;
    localparam logic [CTRL_W-1:0] ALU_BEQ   = 6'b010000;
    localparam logic [CTRL_W-1:0] ALU_BNE   = 6'b010001;
    localparam logic [CTRL_W-1:0] ALU_BLT   = 6'b010100;
    localparam logic [CTRL_W-1:0] ALU_BGE   = 6'b010101;
    localparam logic [CTRL_W-1:0] ALU_BLTU  = 6'b010110;
    localparam logic [CTRL_W-1:0] ALU_BGEU  = 6'b010111;
    localparam logic [CTRL_W-1:0] ALU_PASSB = 6'b100000;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational integer ALU with branch-condition evaluation.
// Compare ops return a zero result; the taken flag is qualified by branch_op.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              branch_op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   result,
    output logic              branch
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic            lt_s, lt_u, eq, cond;

    assign shamt = b[SH_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;

    always_comb begin
        result = '0;
        cond   = 1'b0;
        if (ctrl[5]) begin
            result = b;
        end else if (ctrl[4]) begin
            case (ctrl[2:0])
                3'b000:  cond = eq;
                3'b001:  cond = !eq;
                3'b100:  cond = lt_s;
                3'b101:  cond = !lt_s;
                3'b110:  cond = lt_u;
                3'b111:  cond = !lt_u;
                default: cond = 1'b0;
            endcase
        end else begin
            case (ctrl[2:0])
                3'b000: result = ctrl[3] ? a - b : a + b;
                3'b001: result = a << shamt;
                3'b010: result = {{(XLEN-1){1'b0}}, lt_s};
                3'b011: result = {{(XLEN-1){1'b0}}, lt_u};
                3'b100: result = a ^ b;
                3'b101: result = ctrl[3] ? XLEN'($signed(a) >>> shamt) : a >> shamt;
                3'b110: result = a | b;
                3'b111: result = a & b;
            endcase
        end
    end

    assign branch = branch_op & cond;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// A single output register holds the granted result until the consumer takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RR_INIT = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req0_branch_op,
    input  logic [XLEN-1:0]   req0_a,
    input  logic [XLEN-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic              req1_branch_op,
    input  logic [XLEN-1:0]   req1_a,
    input  logic [XLEN-1:0]   req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_result,
    output logic              rsp_branch,
    output logic              rsp_src,
    output logic [CNT_W-1:0]  grant_count0,
    output logic [CNT_W-1:0]  grant_count1
);

    localparam req_idx_t RR_RST = (RR_INIT != 0);

    state_t                      state, state_nxt;
    req_idx_t                    rr_ptr, sel;
    logic                        slot_free, accept;
    logic [1:0]                  req_valid, gnt;
    logic [1:0][CNT_W-1:0]       grant_cnt;
    logic [CTRL_W-1:0]           alu_ctrl;
    logic                        alu_br_op, alu_branch;
    logic [XLEN-1:0]             alu_a, alu_b, alu_result;

    assign req_valid = {req1_valid, req0_valid};

    // reset_n gates the slot so no request is acknowledged while held in reset
    assign slot_free = reset_n & ((state == EMPTY) | rsp_ready);

    always_comb begin
        gnt = '0;
        if (slot_free) begin
            if (req_valid == 2'b11) gnt[rr_ptr] = 1'b1;
            else                    gnt = req_valid;
        end
    end

    assign accept     = |gnt;
    assign sel        = gnt[1];
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign alu_ctrl  = sel ? req1_ctrl      : req0_ctrl;
    assign alu_br_op = sel ? req1_branch_op : req0_branch_op;
    assign alu_a     = sel ? req1_a         : req0_a;
    assign alu_b     = sel ? req1_b         : req0_b;

    alu_arbiter_alu #(.XLEN(XLEN)) u_alu (
        .ctrl      (alu_ctrl),
        .branch_op (alu_br_op),
        .a         (alu_a),
        .b         (alu_b),
        .result    (alu_result),
        .branch    (alu_branch)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (!accept && rsp_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_result <= '0;
            rsp_branch <= 1'b0;
            rsp_src    <= 1'b0;
            rr_ptr     <= RR_RST;
            grant_cnt  <= '0;
        end else begin
            if (accept) begin
                rsp_result <= alu_result;
                rsp_branch <= alu_branch;
                rsp_src    <= sel;
                rr_ptr     <= ~sel;
            end
            for (int i = 0; i < 2; i++)
                if (gnt[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
        end
    end

    assign rsp_valid    = (state == FULL);
    assign grant_count0 = grant_cnt[0];
    assign grant_count1 = grant_cnt[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: the driver queues expected responses on accept, a monitor checks on handshake.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int XLEN = 32;

    logic            clock, reset_n;
    logic            req0_valid, req0_ready, req0_branch_op;
    logic [5:0]      req0_ctrl;
    logic [XLEN-1:0] req0_a, req0_b;
    logic            req1_valid, req1_ready, req1_branch_op;
    logic [5:0]      req1_ctrl;
    logic [XLEN-1:0] req1_a, req1_b;
    logic            rsp_valid, rsp_ready, rsp_branch, rsp_src;
    logic [XLEN-1:0] rsp_result;
    logic [15:0]     grant_count0, grant_count1;

    typedef struct { logic [5:0] ctrl; logic br; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic tk; } vec_t;
    typedef struct { logic [31:0] res; logic tk; logic src; } exp_t;

    exp_t sb[$];
    vec_t cur0, cur1;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter #(.XLEN(XLEN), .RR_INIT(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_branch_op(req0_branch_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_branch_op(req1_branch_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_branch(rsp_branch), .rsp_src(rsp_src),
        .grant_count0(grant_count0), .grant_count1(grant_count1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] c, input logic br, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] res, input logic tk);
        vec_t v;
        v.ctrl = c; v.br = br; v.a = a; v.b = b; v.res = res; v.tk = tk;
        return v;
    endfunction

    task automatic load(input int i, input vec_t v, input logic valid);
        if (i == 0) begin
            cur0 = v; req0_ctrl = v.ctrl; req0_branch_op = v.br;
            req0_a = v.a; req0_b = v.b; req0_valid = valid;
        end else begin
            cur1 = v; req1_ctrl = v.ctrl; req1_branch_op = v.br;
            req1_a = v.a; req1_b = v.b; req1_valid = valid;
        end
    endtask

    // Called at a negedge with inputs already applied; returns the granted index or -1.
    task automatic tick(output int g);
        logic g0, g1;
        exp_t e;
        #1;
        g0 = req0_valid & req0_ready;
        g1 = req1_valid & req1_ready;
        chk("single_accept", 32'(g0 & g1), 32'd0);
        g = -1;
        if (g0) begin
            e.res = cur0.res; e.tk = cur0.tk; e.src = 1'b0; sb.push_back(e); g = 0;
        end
        if (g1) begin
            e.res = cur1.res; e.tk = cur1.tk; e.src = 1'b1; sb.push_back(e); g = 1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (reset_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got %h expected no response", rsp_result);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_branch", 32'(rsp_branch), 32'(e.tk));
                    chk("rsp_src", 32'(rsp_src), 32'(e.src));
                end
            end
        end
    end

    initial begin : stim
        int g, ng;
        vec_t idle, v_add, v_xor, v_sub, v_and, v_or;
        idle  = mk(ALU_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        v_add = mk(ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0);
        v_xor = mk(ALU_XOR, 1'b0, 32'd6, 32'd3, 32'd5, 1'b0);
        v_sub = mk(ALU_SUB, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
        v_and = mk(ALU_AND, 1'b0, 32'hF0, 32'h3C, 32'h30, 1'b0);
        v_or  = mk(ALU_OR,  1'b0, 32'h0F00, 32'h00F0, 32'h0FF0, 1'b0);

        reset_n = 1'b1; rsp_ready = 1'b0;
        load(0, idle, 1'b1);
        load(1, idle, 1'b1);
        #1 reset_n = 1'b0;
        @(negedge clock);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_src", 32'(rsp_src), 32'd0);
        chk("rst_cnt0", 32'(grant_count0), 32'd0);
        chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // contention from reset: 0,1,0,1
        rsp_ready = 1'b1;
        load(0, v_add, 1'b1);
        load(1, v_xor, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(g);
            chk("rr_grant", 32'(g), 32'(i % 2));
        end
        chk("cnt_eq0", 32'(grant_count0), 32'd2);
        chk("cnt_eq1", 32'(grant_count1), 32'd2);

        // single requester ADD 5+7
        load(1, idle, 1'b0);
        load(0, mk(ALU_ADD, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0), 1'b1);
        tick(g);
        chk("single_grant", 32'(g), 32'd0);
        chk("single_latency", 32'(rsp_valid), 32'd1);
        req0_valid = 1'b0;

        // backpressure on a SUB from req1
        load(1, v_sub, 1'b1);
        tick(g);
        chk("bp_grant", 32'(g), 32'd1);
        req1_a = 32'hDEAD_BEEF;
        rsp_ready = 1'b0;
        load(0, v_and, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'({req1_ready, req0_ready}), 32'd0);
            chk("bp_hold", rsp_result, 32'hFFFF_FFFE);
            chk("bp_src", 32'(rsp_src), 32'd1);
            tick(g);
        end
        rsp_ready = 1'b1;
        load(1, v_or, 1'b1);
        tick(g);
        chk("release_grant", 32'(g), 32'd0);
        tick(g);
        chk("release_next", 32'(g), 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // branch compares and an arithmetic shift
        load(0, mk(ALU_BLT, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1), 1'b1);
        tick(g);
        load(0, mk(ALU_BLTU, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0), 1'b1);
        tick(g);
        load(0, mk(ALU_SRA, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0), 1'b1);
        tick(g);
        req0_valid = 1'b0;
        tick(g);

        // reset while holding a result
        load(0, mk(ALU_ADD, 1'b0, 32'd10, 32'd20, 32'd30, 1'b0), 1'b1);
        tick(g);
        req0_valid = 1'b0; rsp_ready = 1'b0;
        tick(g);
        load(0, v_add, 1'b1);
        load(1, v_xor, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cnt0", 32'(grant_count0), 32'd0);
        chk("mid_rst_cnt1", 32'(grant_count1), 32'd0);
        chk("mid_rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1; rsp_ready = 1'b1;
        tick(g);
        chk("post_rst_ptr", 32'(g), 32'd0);

        // saturation: 65537 further grants to req0
        req1_valid = 1'b0;
        load(0, mk(ALU_ADD, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0), 1'b1);
        ng = 0;
        for (int n = 0; n < 65537; n++) begin
            tick(g);
            if (g == 0) ng++;
            if (n == 65532) chk("cnt_near_sat", 32'(grant_count0), 32'h0000_FFFE);
        end
        chk("sat_grants", 32'(ng), 32'd65537);
        chk("sat_cnt0", 32'(grant_count0), 32'h0000_FFFF);
        chk("sat_cnt1", 32'(grant_count1), 32'd0);

        req0_valid = 1'b0;
        tick(g);
        tick(g);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
